// File: rtl/data_mem_hs.sv
// Word-organised data RAM with valid/ready request and response channels.
// Handles RISC-V byte/half/word loads and stores with a configurable response latency.
module data_mem_hs #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_func3,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t        r_state;
    state_t        w_nextState;
    logic [CW-1:0] r_count;
    logic [31:0]   r_mem [DEPTH_WORDS];
    logic [31:0]   r_rdata;
    logic          r_err;

    logic          w_accept;
    logic [AW-1:0] w_idx;
    logic [1:0]    w_lane;
    logic          w_outOfRange;
    logic [31:0]   w_word;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_err;
    logic [31:0]   w_wmask;
    logic [31:0]   w_wdataRep;
    logic [31:0]   w_ldata;

    assign w_accept     = req_valid && (r_state == IDLE);
    assign w_idx        = req_addr[AW+1:2];
    assign w_lane       = req_addr[1:0];
    assign w_outOfRange = |req_addr[31:AW+2];
    assign w_word       = r_mem[w_idx];
    assign w_byte       = w_word[{w_lane, 3'b000} +: 8];
    assign w_half       = w_word[{w_lane[1], 4'b0000} +: 16];

    // Store data is replicated across lanes so the byte mask alone selects what lands.
    always_comb begin
        w_err      = 1'b0;
        w_wmask    = '0;
        w_wdataRep = req_wdata;
        w_ldata    = '0;
        if (req_write) begin
            case (req_func3)
                3'b000: begin
                    w_wmask    = 32'h0000_00FF << {w_lane, 3'b000};
                    w_wdataRep = {4{req_wdata[7:0]}};
                end
                3'b001: begin
                    w_err      = w_lane[0];
                    w_wmask    = 32'h0000_FFFF << {w_lane[1], 4'b0000};
                    w_wdataRep = {2{req_wdata[15:0]}};
                end
                3'b010: begin
                    w_err   = (w_lane != 2'b00);
                    w_wmask = 32'hFFFF_FFFF;
                end
                default: w_err = 1'b1;
            endcase
        end else begin
            case (req_func3)
                3'b000: w_ldata = {{24{w_byte[7]}}, w_byte};
                3'b100: w_ldata = {24'h0, w_byte};
                3'b001: begin
                    w_err   = w_lane[0];
                    w_ldata = {{16{w_half[15]}}, w_half};
                end
                3'b101: begin
                    w_err   = w_lane[0];
                    w_ldata = {16'h0, w_half};
                end
                3'b010: begin
                    w_err   = (w_lane != 2'b00);
                    w_ldata = w_word;
                end
                default: w_err = 1'b1;
            endcase
        end
        if (w_outOfRange) begin
            w_err = 1'b1;
        end
        if (w_err) begin
            w_wmask = '0;
            w_ldata = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH_WORDS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_accept && req_write) begin
            r_mem[w_idx] <= (w_word & ~w_wmask) | (w_wdataRep & w_wmask);
        end
    end

    // Result is captured at accept so later request-bus changes cannot disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_accept) begin
            r_rdata <= w_ldata;
            r_err   <= w_err;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= CW'(LATENCY - 1);
        end else if ((r_state == WAIT) && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        req_ready   = 1'b0;
        rsp_valid   = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = reset_n;
                if (w_accept) begin
                    w_nextState = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                if (r_count == CW'(1)) begin
                    w_nextState = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;

endmodule

// File: tb/tb_data_mem_hs.sv
// Directed bench for data_mem_hs: one instance at latency 1, one at latency 3.
module tb_data_mem_hs;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        reqValid1 = 1'b0;
    logic        reqValid3 = 1'b0;
    logic        reqWrite = 1'b0;
    logic [31:0] reqAddr = '0;
    logic [31:0] reqWdata = '0;
    logic [2:0]  reqFunc3 = '0;
    logic        rspReady = 1'b1;
    logic        reqReady1, reqReady3, rspValid1, rspValid3, rspErr1, rspErr3;
    logic [31:0] rspRdata1, rspRdata3;
    logic        sel = 1'b0;
    logic        selReqReady, selRspValid, selRspErr;
    logic [31:0] selRspRdata;
    int          testsRun = 0;
    int          testsFailed = 0;

    always #5 clk = ~clk;

    data_mem_hs #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .req_valid(reqValid1), .req_ready(reqReady1),
        .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata), .req_func3(reqFunc3),
        .rsp_valid(rspValid1), .rsp_ready(rspReady), .rsp_rdata(rspRdata1), .rsp_err(rspErr1)
    );

    data_mem_hs #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .req_valid(reqValid3), .req_ready(reqReady3),
        .req_write(reqWrite), .req_addr(reqAddr), .req_wdata(reqWdata), .req_func3(reqFunc3),
        .rsp_valid(rspValid3), .rsp_ready(rspReady), .rsp_rdata(rspRdata3), .rsp_err(rspErr3)
    );

    assign selReqReady = sel ? reqReady3 : reqReady1;
    assign selRspValid = sel ? rspValid3 : rspValid1;
    assign selRspRdata = sel ? rspRdata3 : rspRdata1;
    assign selRspErr   = sel ? rspErr3 : rspErr1;

    // Runs one transaction with rsp_ready high; the request bus is scrambled right after accept.
    task automatic doTxn(input logic s, input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] f, output logic [31:0] rd, output logic er, output int lat);
        sel = s;
        @(negedge clk);
        testsRun++;
        if (selReqReady !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL req_ready_idle addr=%h got=%b want=1", a, selReqReady);
        end
        reqWrite = w; reqAddr = a; reqWdata = d; reqFunc3 = f;
        if (s) reqValid3 = 1'b1; else reqValid1 = 1'b1;
        @(posedge clk);
        #1;
        reqValid1 = 1'b0; reqValid3 = 1'b0;
        reqWrite = ~w; reqAddr = 32'h0000_0014; reqWdata = ~d; reqFunc3 = 3'b011;
        lat = 1;
        @(negedge clk);
        while (!selRspValid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        rd = selRspRdata;
        er = selRspErr;
        if (!selRspValid) begin
            testsRun++;
            testsFailed++;
            $display("[TB] FAIL rsp_timeout addr=%h got=no rsp_valid want=rsp_valid", a);
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        @(negedge clk);
        testsRun++;
        if ({reqReady1, rspValid1, rspErr1, rspRdata1} !== 35'h0) begin
            testsFailed++;
            $display("[TB] FAIL reset_outputs got=%b/%b/%b/%h want=0/0/0/0", reqReady1, rspValid1, rspErr1, rspRdata1);
        end
        reset_n = 1'b1;
        @(negedge clk);
        testsRun++;
        if (reqReady1 !== 1'b1 || reqReady3 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_ready got=%b%b want=11", reqReady1, reqReady3);
        end
    endtask

    task automatic test_word();
        logic [31:0] rd; logic er; int lat;
        doTxn(1'b0, 1'b1, 32'h8, 32'hFFFF_FFFF, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sw_rsp got=%h/%b want=00000000/0", rd, er);
        end
        doTxn(1'b0, 1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'hFFFF_FFFF || er !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL lw_8 got=%h/%b want=ffffffff/0", rd, er);
        end
        testsRun++;
        if (lat !== 1) begin
            testsFailed++;
            $display("[TB] FAIL lat1 got=%0d want=1", lat);
        end
    endtask

    task automatic test_byte();
        logic [31:0] rd; logic er; int lat;
        doTxn(1'b0, 1'b1, 32'h14, 32'hABCD_EDEF, 3'b010, rd, er, lat);
        doTxn(1'b0, 1'b1, 32'h15, 32'h0000_0012, 3'b000, rd, er, lat);
        doTxn(1'b0, 1'b0, 32'h14, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'hABCD_12EF) begin
            testsFailed++;
            $display("[TB] FAIL sb_merge got=%h want=abcd12ef", rd);
        end
        doTxn(1'b0, 1'b0, 32'h17, 32'h0, 3'b000, rd, er, lat);
        testsRun++;
        if (rd !== 32'hFFFF_FFAB) begin
            testsFailed++;
            $display("[TB] FAIL lb_17 got=%h want=ffffffab", rd);
        end
        doTxn(1'b0, 1'b0, 32'h17, 32'h0, 3'b100, rd, er, lat);
        testsRun++;
        if (rd !== 32'h0000_00AB) begin
            testsFailed++;
            $display("[TB] FAIL lbu_17 got=%h want=000000ab", rd);
        end
        doTxn(1'b0, 1'b0, 32'h14, 32'h0, 3'b000, rd, er, lat);
        testsRun++;
        if (rd !== 32'hFFFF_FFEF) begin
            testsFailed++;
            $display("[TB] FAIL lb_14 got=%h want=ffffffef", rd);
        end
    endtask

    task automatic test_half();
        logic [31:0] rd; logic er; int lat;
        doTxn(1'b0, 1'b1, 32'h18, 32'h1122_5566, 3'b010, rd, er, lat);
        doTxn(1'b0, 1'b1, 32'h1A, 32'hFFFF_8001, 3'b001, rd, er, lat);
        doTxn(1'b0, 1'b0, 32'h1A, 32'h0, 3'b001, rd, er, lat);
        testsRun++;
        if (rd !== 32'hFFFF_8001) begin
            testsFailed++;
            $display("[TB] FAIL lh_1a got=%h want=ffff8001", rd);
        end
        doTxn(1'b0, 1'b0, 32'h1A, 32'h0, 3'b101, rd, er, lat);
        testsRun++;
        if (rd !== 32'h0000_8001) begin
            testsFailed++;
            $display("[TB] FAIL lhu_1a got=%h want=00008001", rd);
        end
        doTxn(1'b0, 1'b0, 32'h18, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'h8001_5566) begin
            testsFailed++;
            $display("[TB] FAIL sh_merge got=%h want=80015566", rd);
        end
        doTxn(1'b0, 1'b0, 32'h18, 32'h0, 3'b101, rd, er, lat);
        testsRun++;
        if (rd !== 32'h0000_5566) begin
            testsFailed++;
            $display("[TB] FAIL lhu_18 got=%h want=00005566", rd);
        end
    endtask

    task automatic test_errors();
        logic [31:0] rd; logic er; int lat;
        doTxn(1'b0, 1'b0, 32'h6, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL lw_misaligned got=%h/%b want=00000000/1", rd, er);
        end
        doTxn(1'b0, 1'b1, 32'h3, 32'h1234, 3'b001, rd, er, lat);
        testsRun++;
        if (er !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sh_misaligned got=%b want=1", er);
        end
        doTxn(1'b0, 1'b0, 32'h0, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mem_after_bad_sh got=%h/%b want=00000000/0", rd, er);
        end
        doTxn(1'b0, 1'b0, 32'h8, 32'h0, 3'b011, rd, er, lat);
        testsRun++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL load_f3_011 got=%h/%b want=00000000/1", rd, er);
        end
        doTxn(1'b0, 1'b0, 32'h400, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (er !== 1'b1 || rd !== 32'h0) begin
            testsFailed++;
            $display("[TB] FAIL lw_out_of_range got=%h/%b want=00000000/1", rd, er);
        end
        doTxn(1'b0, 1'b1, 32'h14, 32'h5555_5555, 3'b100, rd, er, lat);
        testsRun++;
        if (er !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL store_f3_100 got=%b want=1", er);
        end
        doTxn(1'b0, 1'b0, 32'h14, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'hABCD_12EF || er !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL mem_after_bad_store got=%h/%b want=abcd12ef/0", rd, er);
        end
        doTxn(1'b0, 1'b0, 32'h17, 32'h0, 3'b101, rd, er, lat);
        testsRun++;
        if (er !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL lhu_odd got=%b want=1", er);
        end
    endtask

    task automatic test_latency();
        logic [31:0] rd; logic er; int lat;
        doTxn(1'b1, 1'b1, 32'h8, 32'hFFFF_FFFF, 3'b010, rd, er, lat);
        doTxn(1'b1, 1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'hFFFF_FFFF || lat !== 3) begin
            testsFailed++;
            $display("[TB] FAIL lat3_lw got=%h lat %0d want=ffffffff lat 3", rd, lat);
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic holdOk;
        sel = 1'b1;
        rspReady = 1'b0;
        @(negedge clk);
        reqWrite = 1'b0; reqAddr = 32'h8; reqFunc3 = 3'b010; reqValid3 = 1'b1;
        @(posedge clk);
        #1;
        reqValid3 = 1'b0; reqAddr = 32'h0;
        lat = 1;
        @(negedge clk);
        while (!rspValid3 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        testsRun++;
        if (lat !== 3) begin
            testsFailed++;
            $display("[TB] FAIL bp_first_valid got=%0d want=3", lat);
        end
        holdOk = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (rspValid3 !== 1'b1 || rspRdata3 !== 32'hFFFF_FFFF || rspErr3 !== 1'b0 || reqReady3 !== 1'b0)
                holdOk = 1'b0;
        end
        testsRun++;
        if (holdOk !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_hold got=%b/%h/%b want=1/ffffffff/0", rspValid3, rspRdata3, reqReady3);
        end
        rspReady = 1'b1;
        @(negedge clk);
        testsRun++;
        if (rspValid3 !== 1'b0 || reqReady3 !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL bp_release got=%b/%b want=0/1", rspValid3, reqReady3);
        end
    endtask

    task automatic test_reset_abort();
        logic [31:0] rd; logic er; int lat;
        logic sawValid;
        sel = 1'b1;
        sawValid = 1'b0;
        @(negedge clk);
        reqWrite = 1'b0; reqAddr = 32'h8; reqFunc3 = 3'b010; reqValid3 = 1'b1;
        @(posedge clk);
        #1;
        reqValid3 = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (rspValid3 !== 1'b0 || reqReady3 !== 1'b0) sawValid = 1'b1;
        end
        reset_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (rspValid3 !== 1'b0) sawValid = 1'b1;
        end
        testsRun++;
        if (sawValid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_no_rsp got=rsp_valid or req_ready seen want=quiet");
        end
        doTxn(1'b1, 1'b0, 32'h8, 32'h0, 3'b010, rd, er, lat);
        testsRun++;
        if (rd !== 32'h0 || er !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL abort_mem_cleared got=%h/%b want=00000000/0", rd, er);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_word();
        test_byte();
        test_half();
        test_errors();
        test_latency();
        test_backpressure();
        test_reset_abort();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
